fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS32 pipeline. Holds the program counter, drives the
//  combinational instructionMemory address, and captures the returned word into the
//  IF/ID pipeline register. Handles stall from hazard unit and redirect (branch/jump)
//  with bubble insertion. Sits between the hazard/branch logic and the ID stage.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  MEM_DEPTH  256            instruction memory words; fetches at or beyond this are out of range
//  NOP_WORD   32'h0000_0000  word injected into IF/ID on bubble (sll $0,$0,0)
// PORTS
//  clk             in   1   pipeline clock, rising edge
//  rst             in   1   asynchronous reset, active-high
//  stall           in   1   hold PC and IF/ID (load-use hazard)
//  branchTaken     in   1   branch resolved taken; redirect to branchTarget
//  branchTarget    in   32  branch destination byte address
//  jump            in   1   j/jal decoded in ID; redirect to jumpTarget
//  jumpTarget      in   32  jump destination byte address
//  instrIn         in   32  word from instructionMemory (same-cycle, combinational)
//  pcOut           out  32  current PC, to instructionMemory address
//  ifidInstruction out  32  registered instruction to ID
//  ifidPcPlus4     out  32  registered PC+4 of that instruction
//  ifidValid       out  1   1 = ifidInstruction is real, 0 = bubble
//  alignErr        out  1   registered 1-cycle pulse: redirect target had [1:0]!=0
//  rangeErr        out  1   level: pcOut word index >= MEM_DEPTH
//  fetchCount      out  32  number of valid instructions delivered to ID
// BEHAVIOUR
//  - Clock is clk; reset is rst, asynchronous, active-high.
//  - Reset: pc=RESET_PC; ifidInstruction=NOP_WORD; ifidPcPlus4=0; ifidValid=0;
//    alignErr=0; fetchCount=0. Deassertion: first fetch at RESET_PC on next edge.
//  - pcOut = pc, purely from register. Fetch latency: 1 cycle (word at pc visible on
//    ifid* after the next rising edge).
//  - Per-edge priority: redirect > stall > advance.
//    redirect = branchTaken | jump; branchTaken beats jump when both set (older instr).
//    redirect: pc <= target & ~32'h3; ifidInstruction<=NOP_WORD, ifidValid<=0
//      (squashes the wrong-path word fetched this cycle); ignores stall.
//    stall (no redirect): pc, ifid*, fetchCount all hold.
//    advance: pc <= pc+4; ifidInstruction<=instrIn; ifidPcPlus4<=pc+4; ifidValid<=1.
//  - Out of range (rangeErr=1) on advance: ifid gets NOP_WORD, ifidValid=0, pc still
//    advances (wraps if it keeps going); never forwards an undefined memory word.
//  - pc+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
//  - alignErr <= 1 for exactly one cycle after a redirect whose selected target[1:0]!=0;
//    0 otherwise, including during stall.
//  - fetchCount increments by 1 on each edge that loads ifidValid=1; wraps at 2^32.
//  - rst asserted mid-operation clears all state immediately, irrespective of clk.
// STRUCTURE
//  - Shared package mips_pkg: NOP_WORD, RESET_PC, instruction width (32), word-address
//    shift (2); same constants used by instructionMemory and decode.
//  - One sub-module: ifid_register (instruction, pcPlus4, valid; inputs load, bubble,
//    async rst). PC register, next-PC mux, range/align checks and counter stay in
//    fetch_stage.
// TESTING
//  1 Reset then 4 free cycles, memory words A,B,C,D at 0..12 -> pcOut 0,4,8,12,16;
//    ifidInstruction A..D one cycle late; ifidPcPlus4 4,8,12,16; fetchCount=4.
//  2 Stall high 2 cycles at pc=8 -> pcOut stays 8, ifid holds B/8, fetchCount frozen;
//    on release C captured with ifidPcPlus4=12.
//  3 branchTaken=1, branchTarget=0x40 together with stall=1 and jump=1/jumpTarget=0x80
//    -> next pcOut=0x40, ifidValid=0, ifidInstruction=NOP_WORD; next word from 0x40.
//  4 jump to 0x42 -> pcOut=0x40, alignErr high exactly one cycle.
//  5 Run pc to 0x3FC then advance -> pcOut=0x400, rangeErr=1, ifidValid=0 following edge,
//    fetchCount unchanged; pc=0xFFFFFFFC advances to 0.
//  6 Assert rst mid-stream between clock edges -> all outputs at reset values at once,
//    pcOut=RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Constants shared by the MIPS32 front end (fetch, instruction memory, decode).
// Provides the bubble word, reset PC, instruction width, word-address shift and next-PC select.
package mips_pkg;

  localparam int          INSTR_W    = 32;
  localparam int          WORD_SHIFT = 2;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_ADV    = 2'd0,
    PC_HOLD   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_JUMP   = 2'd3
  } pc_sel_e;

  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return byte_addr >> WORD_SHIFT;
  endfunction

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: 1-cycle capture of instruction, PC+4 and valid.
// bubble overrides load and leaves PC+4 untouched; with neither set every field holds.
module ifid_register
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] BUBBLE_WORD = NOP_WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr_next,
  input  logic [31:0]        pc_plus4_next,
  output logic [INSTR_W-1:0] instruction,
  output logic [31:0]        pc_plus4,
  output logic               valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= BUBBLE_WORD;
      pc_plus4    <= 32'h0;
      valid       <= 1'b0;
    end else if (bubble) begin
      instruction <= BUBBLE_WORD;
      valid       <= 1'b0;
    end else if (load) begin
      instruction <= instr_next;
      pc_plus4    <= pc_plus4_next;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS32 IF stage: PC register, next-PC mux (redirect > stall > advance), IF/ID capture.
// Fetch latency 1 cycle; stall holds PC, IF/ID and count; a redirect squashes the fetched word.
module fetch_stage
  import mips_pkg::pc_sel_e;
  import mips_pkg::PC_ADV;
  import mips_pkg::PC_HOLD;
  import mips_pkg::PC_BRANCH;
  import mips_pkg::PC_JUMP;
  import mips_pkg::word_index;
#(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter int          MEM_DEPTH = 256,
  parameter logic [31:0] NOP_WORD  = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  input  logic [31:0] jumpTarget,
  input  logic [31:0] instrIn,
  output logic [31:0] pcOut,
  output logic [31:0] ifidInstruction,
  output logic [31:0] ifidPcPlus4,
  output logic        ifidValid,
  output logic        alignErr,
  output logic        rangeErr,
  output logic [31:0] fetchCount
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] target;
  logic        redirect;
  logic        range_err;
  logic        load;
  logic        bubble;
  pc_sel_e     sel;

  assign pc_plus4  = pc + 32'd4;
  assign range_err = word_index(pc) >= 32'(MEM_DEPTH);
  assign redirect  = branchTaken | jump;
  // branch belongs to the older instruction, so it wins over a simultaneous jump
  assign target    = branchTaken ? branchTarget : jumpTarget;

  always_comb begin
    sel = PC_ADV;
    if (branchTaken)  sel = PC_BRANCH;
    else if (jump)    sel = PC_JUMP;
    else if (stall)   sel = PC_HOLD;
  end

  always_comb begin
    pc_next = pc;
    case (sel)
      PC_BRANCH, PC_JUMP: pc_next = target & ~32'h3;
      PC_ADV:             pc_next = pc_plus4;
      default:            pc_next = pc;
    endcase
  end

  // out-of-range words are never forwarded: they become bubbles while pc keeps moving
  assign bubble = redirect | (~stall & range_err);
  assign load   = (sel == PC_ADV) & ~range_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      alignErr   <= 1'b0;
      fetchCount <= 32'h0;
    end else begin
      pc         <= pc_next;
      alignErr   <= redirect & (target[1:0] != 2'b00);
      if (load) fetchCount <= fetchCount + 32'd1;
    end
  end

  ifid_register #(
    .BUBBLE_WORD(NOP_WORD)
  ) u_ifid (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .bubble       (bubble),
    .instr_next   (instrIn),
    .pc_plus4_next(pc_plus4),
    .instruction  (ifidInstruction),
    .pc_plus4     (ifidPcPlus4),
    .valid        (ifidValid)
  );

  assign pcOut    = pc;
  assign rangeErr = range_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a rule-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] OOR_WORD = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jumpTarget = 32'h0;
  logic [31:0] instrIn;
  logic [31:0] pcOut;
  logic [31:0] ifidInstruction;
  logic [31:0] ifidPcPlus4;
  logic        ifidValid;
  logic        alignErr;
  logic        rangeErr;
  logic [31:0] fetchCount;

  logic [31:0] mem [256];

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_align;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign instrIn = (pcOut[31:2] < 30'd256) ? mem[pcOut[9:2]] : OOR_WORD;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jump(jump), .jumpTarget(jumpTarget), .instrIn(instrIn),
    .pcOut(pcOut), .ifidInstruction(ifidInstruction), .ifidPcPlus4(ifidPcPlus4),
    .ifidValid(ifidValid), .alignErr(alignErr), .rangeErr(rangeErr),
    .fetchCount(fetchCount)
  );

  function automatic logic model_range(input logic [31:0] pc);
    return (pc / 4) >= 256;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_count = 32'h0;
    m_valid = 1'b0; m_align = 1'b0;
  endtask

  // apply current inputs to model, then take one clock edge and settle
  task automatic tick();
    logic [31:0] tgt;
    if (branchTaken || jump) begin
      tgt = branchTaken ? branchTarget : jumpTarget;
      m_align = (tgt % 4) != 0;
      m_pc = tgt - (tgt % 4);
      m_instr = NOP;
      m_valid = 1'b0;
    end else begin
      m_align = 1'b0;
      if (!stall) begin
        if (model_range(m_pc)) begin
          m_instr = NOP;
          m_valid = 1'b0;
        end else begin
          m_instr = mem[m_pc / 4];
          m_pc4 = m_pc + 4;
          m_valid = 1'b1;
          m_count = m_count + 1;
        end
        m_pc = m_pc + 4;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    stall = 0; branchTaken = 0; jump = 0; branchTarget = 0; jumpTarget = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    model_reset();
    n_cmp++; if (pcOut !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h expected %h", pcOut, 32'h0); end
    n_cmp++; if (ifidValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", ifidValid); end
    n_cmp++; if (ifidInstruction !== NOP) begin n_err++; $display("FAIL reset_instr: got %h expected %h", ifidInstruction, NOP); end
    n_cmp++; if (ifidPcPlus4 !== 32'h0) begin n_err++; $display("FAIL reset_pc4: got %h expected 0", ifidPcPlus4); end
    n_cmp++; if (fetchCount !== 32'h0 || alignErr !== 1'b0) begin n_err++; $display("FAIL reset_cnt_align: got %h/%b expected 0/0", fetchCount, alignErr); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (pcOut !== 32'(4 * k)) begin n_err++; $display("FAIL seq_pc[%0d]: got %h expected %h", k, pcOut, 32'(4 * k)); end
      n_cmp++; if (ifidInstruction !== mem[k - 1] || ifidValid !== 1'b1) begin n_err++; $display("FAIL seq_instr[%0d]: got %h/%b expected %h/1", k, ifidInstruction, ifidValid, mem[k - 1]); end
      n_cmp++; if (ifidPcPlus4 !== 32'(4 * k)) begin n_err++; $display("FAIL seq_pc4[%0d]: got %h expected %h", k, ifidPcPlus4, 32'(4 * k)); end
    end
    n_cmp++; if (fetchCount !== 32'd4) begin n_err++; $display("FAIL seq_count: got %0d expected 4", fetchCount); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (pcOut !== 32'h8) begin n_err++; $display("FAIL stall_pc: got %h expected 8", pcOut); end
      n_cmp++; if (ifidInstruction !== mem[1] || ifidPcPlus4 !== 32'h8) begin n_err++; $display("FAIL stall_ifid: got %h/%h expected %h/8", ifidInstruction, ifidPcPlus4, mem[1]); end
      n_cmp++; if (fetchCount !== 32'd2 || alignErr !== 1'b0) begin n_err++; $display("FAIL stall_cnt: got %0d/%b expected 2/0", fetchCount, alignErr); end
    end
    stall = 1'b0;
    tick();
    n_cmp++; if (ifidInstruction !== mem[2] || ifidPcPlus4 !== 32'hC || pcOut !== 32'hC) begin n_err++; $display("FAIL stall_release: got %h/%h/%h expected %h/c/c", ifidInstruction, ifidPcPlus4, pcOut, mem[2]); end
  endtask

  task automatic test_redirect_priority();
    do_reset();
    tick(); tick();
    branchTaken = 1; branchTarget = 32'h40; stall = 1; jump = 1; jumpTarget = 32'h80;
    tick();
    idle_inputs();
    n_cmp++; if (pcOut !== 32'h40) begin n_err++; $display("FAIL prio_pc: got %h expected 40", pcOut); end
    n_cmp++; if (ifidValid !== 1'b0 || ifidInstruction !== NOP) begin n_err++; $display("FAIL prio_bubble: got %h/%b expected %h/0", ifidInstruction, ifidValid, NOP); end
    n_cmp++; if (fetchCount !== 32'd2) begin n_err++; $display("FAIL prio_count: got %0d expected 2", fetchCount); end
    tick();
    n_cmp++; if (ifidInstruction !== mem[16] || ifidPcPlus4 !== 32'h44 || ifidValid !== 1'b1) begin n_err++; $display("FAIL prio_next: got %h/%h/%b expected %h/44/1", ifidInstruction, ifidPcPlus4, ifidValid, mem[16]); end
  endtask

  task automatic test_misalign();
    jump = 1; jumpTarget = 32'h42;
    tick();
    idle_inputs();
    n_cmp++; if (pcOut !== 32'h40 || alignErr !== 1'b1) begin n_err++; $display("FAIL align_hit: got %h/%b expected 40/1", pcOut, alignErr); end
    tick();
    n_cmp++; if (alignErr !== 1'b0) begin n_err++; $display("FAIL align_pulse: got %b expected 0", alignErr); end
  endtask

  task automatic test_range_wrap();
    logic [31:0] cnt;
    jump = 1; jumpTarget = 32'h3FC;
    tick();
    idle_inputs();
    n_cmp++; if (rangeErr !== 1'b0) begin n_err++; $display("FAIL range_edge_in: got %b expected 0", rangeErr); end
    tick();
    cnt = fetchCount;
    n_cmp++; if (pcOut !== 32'h400 || rangeErr !== 1'b1 || ifidInstruction !== mem[255]) begin n_err++; $display("FAIL range_enter: got %h/%b/%h expected 400/1/%h", pcOut, rangeErr, ifidInstruction, mem[255]); end
    tick();
    n_cmp++; if (ifidValid !== 1'b0 || ifidInstruction !== NOP || fetchCount !== cnt || pcOut !== 32'h404) begin n_err++; $display("FAIL range_bubble: got %b/%h/%0d/%h expected 0/%h/%0d/404", ifidValid, ifidInstruction, fetchCount, pcOut, NOP, cnt); end
    jump = 1; jumpTarget = 32'hFFFF_FFFC;
    tick();
    idle_inputs();
    tick();
    n_cmp++; if (pcOut !== 32'h0 || rangeErr !== 1'b0 || alignErr !== 1'b0) begin n_err++; $display("FAIL pc_wrap: got %h/%b/%b expected 0/0/0", pcOut, rangeErr, alignErr); end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      stall = (r < 25);
      branchTaken = ($urandom_range(0, 9) == 0);
      jump = ($urandom_range(0, 9) == 0);
      branchTarget = 32'($urandom_range(0, 320)) * 4 + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      jumpTarget   = 32'($urandom_range(0, 320)) * 4 + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      tick();
      n_cmp++; if (pcOut !== m_pc || rangeErr !== model_range(m_pc)) begin n_err++; $display("FAIL rnd_pc[%0d]: got %h/%b expected %h/%b", i, pcOut, rangeErr, m_pc, model_range(m_pc)); end
      n_cmp++; if (ifidInstruction !== m_instr || ifidValid !== m_valid) begin n_err++; $display("FAIL rnd_ifid[%0d]: got %h/%b expected %h/%b", i, ifidInstruction, ifidValid, m_instr, m_valid); end
      n_cmp++; if (ifidPcPlus4 !== m_pc4) begin n_err++; $display("FAIL rnd_pc4[%0d]: got %h expected %h", i, ifidPcPlus4, m_pc4); end
      n_cmp++; if (alignErr !== m_align || fetchCount !== m_count) begin n_err++; $display("FAIL rnd_flags[%0d]: got %b/%0d expected %b/%0d", i, alignErr, fetchCount, m_align, m_count); end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (pcOut !== 32'h0 || ifidValid !== 1'b0 || ifidInstruction !== NOP) begin n_err++; $display("FAIL arst_ifid: got %h/%b/%h expected 0/0/%h", pcOut, ifidValid, ifidInstruction, NOP); end
    n_cmp++; if (ifidPcPlus4 !== 32'h0 || fetchCount !== 32'h0 || alignErr !== 1'b0) begin n_err++; $display("FAIL arst_misc: got %h/%0d/%b expected 0/0/0", ifidPcPlus4, fetchCount, alignErr); end
    #2;
    rst = 1'b0;
    model_reset();
    tick();
    n_cmp++; if (pcOut !== 32'h4 || ifidInstruction !== mem[0] || ifidValid !== 1'b1) begin n_err++; $display("FAIL arst_restart: got %h/%h/%b expected 4/%h/1", pcOut, ifidInstruction, ifidValid, mem[0]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h010A_5820;
    mem[3] = 32'hAC0B_0010;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_priority();
    test_misalign();
    test_range_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
